// File: rtl/remote_cmd_seq.sv
// Command sequencer for the remote end of the UART link. It queues host commands in a FIFO,
// sends each one through RemoteComm, checks the response byte and retries on NAK or timeout.
`timescale 1ns/1ps
module remote_cmd_seq #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  ACK       = 8'hA5,
    parameter int unsigned TO_CYCLES = 2_000_000,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [15:0] push_cmd,
    output logic        full,
    output logic        empty,
    output logic        snd_cmd,
    output logic [15:0] cmd,
    input  logic        cmd_snt,
    input  logic        resp_rx_rdy,
    input  logic [7:0]  resp_rx_data,
    output logic        resp_clr_rx_rdy,
    output logic        busy,
    output logic [7:0]  last_resp,
    output logic [7:0]  ack_cnt,
    output logic        err,
    output logic        ovf,
    input  logic        err_clr
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(TO_CYCLES + 1);
    localparam int unsigned RtyW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StWaitSnt, StWaitResp} state_e;

    state_e            state_q, state_d;
    logic [15:0]       mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              snd_q, snd_d, clr_q, clr_d, busy_q, busy_d;
    logic [15:0]       cmd_q, cmd_d;
    logic [7:0]        last_q, last_d, ack_q, ack_d;
    logic              err_q, err_d, ovf_q, ovf_d;
    logic [RtyW-1:0]   retry_q, retry_d;
    logic [CntW-1:0]   to_cnt_q, to_cnt_d;
    logic              push_ok, pop, rdy, fail, err_set;

    assign push_ok = push && !full_q;
    // While the clear pulse is out, RemoteComm still shows the byte we just consumed.
    assign rdy     = resp_rx_rdy && !clr_q;

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        snd_d    = 1'b0;
        clr_d    = 1'b0;
        last_d   = last_q;
        ack_d    = ack_q;
        retry_d  = retry_q;
        to_cnt_d = to_cnt_q;
        pop      = 1'b0;
        fail     = 1'b0;
        err_set  = 1'b0;

        unique case (state_q)
            StIdle: begin
                clr_d = rdy;
                if (!empty_q) begin
                    cmd_d   = mem_q[rd_ptr_q];
                    state_d = StSend;
                end
            end
            StSend: begin
                clr_d   = rdy;
                snd_d   = 1'b1;
                state_d = StWaitSnt;
            end
            StWaitSnt: begin
                clr_d = rdy;
                if (cmd_snt) begin
                    to_cnt_d = '0;
                    state_d  = StWaitResp;
                end
            end
            StWaitResp: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (rdy) begin
                    last_d = resp_rx_data;
                    clr_d  = 1'b1;
                    if (resp_rx_data == ACK) begin
                        pop     = 1'b1;
                        ack_d   = (ack_q == 8'hFF) ? ack_q : ack_q + 8'd1;
                        retry_d = '0;
                        state_d = StIdle;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (to_cnt_q == CntW'(TO_CYCLES - 1)) begin
                    fail = 1'b1;
                end
                if (fail) begin
                    state_d = StIdle;
                    if (retry_q < RtyW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                    end else begin
                        pop     = 1'b1;
                        err_set = 1'b1;
                        retry_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // FIFO bookkeeping; fullness is judged on the registered count, before any same-cycle pop.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (PtrW + 1)'(DEPTH));
        empty_d = (count_d == '0);

        err_d = err_q;
        ovf_d = ovf_q;
        if (err_clr) begin
            err_d = 1'b0;
            ovf_d = 1'b0;
        end
        if (err_set) err_d = 1'b1;
        if (push && full_q) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_cmd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            snd_q    <= 1'b0;
            clr_q    <= 1'b0;
            busy_q   <= 1'b0;
            cmd_q    <= '0;
            last_q   <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            retry_q  <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            snd_q    <= snd_d;
            clr_q    <= clr_d;
            busy_q   <= busy_d;
            cmd_q    <= cmd_d;
            last_q   <= last_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            retry_q  <= retry_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign full            = full_q;
    assign empty           = empty_q;
    assign snd_cmd         = snd_q;
    assign cmd             = cmd_q;
    assign resp_clr_rx_rdy = clr_q;
    assign busy            = busy_q;
    assign last_resp       = last_q;
    assign ack_cnt         = ack_q;
    assign err             = err_q;
    assign ovf             = ovf_q;

endmodule

// File: tb/tb_remote_cmd_seq.sv
// Bench for remote_cmd_seq: directed host/RemoteComm stimulus with a scoreboard of the
// commands expected on each snd_cmd pulse.
`timescale 1ns/1ps
module tb_remote_cmd_seq;

    logic        clk, rst_n, push, cmd_snt, resp_rx_rdy, err_clr;
    logic [15:0] push_cmd, cmd;
    logic [7:0]  resp_rx_data, last_resp, ack_cnt;
    logic        full, empty, snd_cmd, resp_clr_rx_rdy, busy, err, ovf;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_ack  = 0;
    int          n;
    logic        snd_prev = 1'b0;
    logic [15:0] exp_q[$];

    remote_cmd_seq #(
        .DEPTH(4), .ACK(8'hA5), .TO_CYCLES(100), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_cmd(push_cmd), .full(full),
        .empty(empty), .snd_cmd(snd_cmd), .cmd(cmd), .cmd_snt(cmd_snt),
        .resp_rx_rdy(resp_rx_rdy), .resp_rx_data(resp_rx_data),
        .resp_clr_rx_rdy(resp_clr_rx_rdy), .busy(busy), .last_resp(last_resp),
        .ack_cnt(ack_cnt), .err(err), .ovf(ovf), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    // Monitor: each snd_cmd pulse must be one cycle wide and carry the next expected command.
    always @(negedge clk) begin
        if (snd_cmd) begin
            check("snd_cmd_width", {31'b0, snd_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_snd: got cmd %0h, expected no send", cmd);
            end else begin
                check("sent_cmd", {16'b0, cmd}, {16'b0, exp_q.pop_front()});
            end
        end
        snd_prev = snd_cmd;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_snd"}, {31'b0, snd_cmd}, 32'd0);
        check({tag, "_clr"}, {31'b0, resp_clr_rx_rdy}, 32'd0);
        check({tag, "_cmd"}, {16'b0, cmd}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_last"}, {24'b0, last_resp}, 32'd0);
        check({tag, "_ack"}, {24'b0, ack_cnt}, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
        check({tag, "_ovf"}, {31'b0, ovf}, 32'd0);
        check({tag, "_full"}, {31'b0, full}, 32'd0);
        check({tag, "_empty"}, {31'b0, empty}, 32'd1);
    endtask

    // All drive tasks start and end on a falling edge.
    task automatic do_push(input logic [15:0] v);
        push = 1'b1;
        push_cmd = v;
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic wait_snd(output int cyc);
        cyc = 0;
        while (!snd_cmd && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!snd_cmd) fail_now("snd_cmd_wait");
    endtask

    task automatic pulse_snt();
        cmd_snt = 1'b1;
        @(negedge clk);
        cmd_snt = 1'b0;
    endtask

    // RemoteComm model: hold the byte until the clear pulse is seen.
    task automatic give_resp(input logic [7:0] b);
        int k;
        resp_rx_data = b;
        resp_rx_rdy  = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!resp_clr_rx_rdy && k < 50);
        if (!resp_clr_rx_rdy) fail_now("clr_wait");
        resp_rx_rdy = 1'b0;
        @(negedge clk);
        check("clr_width", {31'b0, resp_clr_rx_rdy}, 32'd0);
    endtask

    task automatic do_txn(input logic [7:0] b);
        int c;
        wait_snd(c);
        pulse_snt();
        give_resp(b);
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; push_cmd = '0; cmd_snt = 1'b0;
        resp_rx_rdy = 1'b0; resp_rx_data = '0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Single command, ACK; snd_cmd appears two edges after the push edge.
        exp_q.push_back(16'h1234);
        do_push(16'h1234);
        check("t1_empty_after_push", {31'b0, empty}, 32'd0);
        wait_snd(n);
        check("t1_push_to_send", n, 32'd2);
        check("t1_busy", {31'b0, busy}, 32'd1);
        pulse_snt();
        give_resp(8'hA5);
        exp_ack++;
        check("t1_ack_cnt", {24'b0, ack_cnt}, exp_ack);
        check("t1_last_resp", {24'b0, last_resp}, 32'hA5);
        check("t1_empty", {31'b0, empty}, 32'd1);
        check("t1_err", {31'b0, err}, 32'd0);
        check("t1_busy_idle", {31'b0, busy}, 32'd0);

        // Fill and overflow with the FSM parked in WAIT_SNT on the first entry.
        exp_q.push_back(16'hA001);
        exp_q.push_back(16'hA002);
        exp_q.push_back(16'hA003);
        exp_q.push_back(16'hA004);
        do_push(16'hA001);
        wait_snd(n);
        do_push(16'hA002);
        do_push(16'hA003);
        check("t2_not_full_at_3", {31'b0, full}, 32'd0);
        do_push(16'hA004);
        check("t2_full_at_4", {31'b0, full}, 32'd1);
        check("t2_no_ovf_yet", {31'b0, ovf}, 32'd0);
        do_push(16'hA005);
        check("t2_ovf", {31'b0, ovf}, 32'd1);
        check("t2_still_full", {31'b0, full}, 32'd1);
        pulse_snt();
        give_resp(8'hA5);
        check("t2_not_full_after_pop", {31'b0, full}, 32'd0);
        do_txn(8'hA5);
        do_txn(8'hA5);
        do_txn(8'hA5);
        exp_ack += 4;
        check("t2_ack_cnt", {24'b0, ack_cnt}, exp_ack);
        check("t2_empty", {31'b0, empty}, 32'd1);

        // NAK then ACK; the resend follows two edges after the response edge.
        exp_q.push_back(16'h5555);
        exp_q.push_back(16'h5555);
        do_push(16'h5555);
        do_txn(8'h5A);
        check("t3_last_nak", {24'b0, last_resp}, 32'h5A);
        wait_snd(n);
        check("t3_resp_to_resend", n, 32'd1);
        pulse_snt();
        give_resp(8'hA5);
        exp_ack++;
        check("t3_ack_cnt", {24'b0, ack_cnt}, exp_ack);
        check("t3_err", {31'b0, err}, 32'd0);
        check("t3_empty", {31'b0, empty}, 32'd1);

        // Retries exhausted: three sends, then the entry is dropped with err.
        repeat (3) exp_q.push_back(16'hBEEF);
        do_push(16'hBEEF);
        do_txn(8'h00);
        do_txn(8'h00);
        check("t4_err_before_last", {31'b0, err}, 32'd0);
        do_txn(8'h00);
        check("t4_err", {31'b0, err}, 32'd1);
        check("t4_empty", {31'b0, empty}, 32'd1);
        check("t4_ack_unchanged", {24'b0, ack_cnt}, exp_ack);
        repeat (6) @(negedge clk);
        check("t4_busy_idle", {31'b0, busy}, 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t4_err_cleared", {31'b0, err}, 32'd0);
        check("t4_ovf_cleared", {31'b0, ovf}, 32'd0);

        // Timeout: counter hits 99 on the 100th edge after cmd_snt, resend two edges later.
        exp_q.push_back(16'h7777);
        exp_q.push_back(16'h7777);
        do_push(16'h7777);
        wait_snd(n);
        pulse_snt();
        wait_snd(n);
        check("t5_timeout_resend", n, 32'd102);
        check("t5_last_unchanged", {24'b0, last_resp}, 32'h00);
        pulse_snt();
        // Response lands on the timeout edge and must be taken as a response.
        repeat (99) @(negedge clk);
        give_resp(8'hA5);
        exp_ack++;
        check("t5_ack_on_timeout_edge", {24'b0, ack_cnt}, exp_ack);
        check("t5_last_resp", {24'b0, last_resp}, 32'hA5);
        repeat (6) @(negedge clk);
        check("t5_empty", {31'b0, empty}, 32'd1);

        // Reset mid WAIT_RESP with another entry queued, then a stale byte in IDLE.
        exp_q.push_back(16'h1111);
        do_push(16'h1111);
        wait_snd(n);
        pulse_snt();
        do_push(16'h2222);
        check("t6_busy", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_empty", {31'b0, empty}, 32'd1);
        check("t6_busy", {31'b0, busy}, 32'd0);
        give_resp(8'h3C);
        check("t6_stale_last", {24'b0, last_resp}, 32'h00);
        check("t6_stale_ack", {24'b0, ack_cnt}, 32'h00);
        repeat (4) @(negedge clk);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/remote_cmd_seq.md
# remote_cmd_seq

Command sequencer for the remote end of the UART link. It buffers 16-bit commands from a host into a small FIFO and issues them one at a time through the RemoteComm transmitter. After each send it waits for the 8-bit response, checks it against the acknowledge code, and retries on NAK or timeout. It sits between the host/test stimulus logic and RemoteComm, and is the only block that drives RemoteComm's send and clear handshakes.

## Interface
- DEPTH, 4 — FIFO entries; power of 2, at least 2
- ACK, 8'hA5 — response value counted as success
- TO_CYCLES, 2_000_000 — response timeout in clocks, counted from `cmd_snt`
- MAX_RETRY, 2 — resends allowed after the first attempt
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- push  in  1  enqueue `push_cmd` this cycle
- push_cmd  in  16  command to enqueue
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- snd_cmd  out  1  one-cycle pulse to RemoteComm; start send of `cmd`
- cmd  out  16  command to RemoteComm; stable from `snd_cmd` until the next `snd_cmd`
- cmd_snt  in  1  pulse from RemoteComm; both bytes are out
- resp_rx_rdy  in  1  level from RemoteComm; a response byte is valid
- resp_rx_data  in  8  response byte
- resp_clr_rx_rdy  out  1  one-cycle pulse; clears RemoteComm's `resp_rx_rdy`
- busy  out  1  FSM is not in IDLE
- last_resp  out  8  most recently received response byte
- ack_cnt  out  8  count of ACKed commands; saturates at 255
- err  out  1  sticky; a command was dropped after exhausting retries
- ovf  out  1  sticky; a push arrived while full
- err_clr  in  1  clears `err` and `ovf`

## Operation
- FIFO:
  - A push when not full writes the tail.
  - A push when full is dropped and sets `ovf`. Fullness is judged before any same-cycle pop.
  - Push and pop in the same cycle when not full: both take effect and the count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SEND, WAIT_SNT, WAIT_RESP.
- IDLE:
  - If `!empty`, load `cmd` from the FIFO head and go to SEND.
  - The head is popped only on completion, never here.
- SEND:
  - Assert `snd_cmd` for one cycle.
  - Go to WAIT_SNT.
- WAIT_SNT:
  - Wait for `cmd_snt`.
  - On `cmd_snt`, load the timeout counter with 0 and go to WAIT_RESP.
- WAIT_RESP: the counter increments every cycle.
  - On `resp_rx_rdy`:
    - Capture `last_resp`.
    - Pulse `resp_clr_rx_rdy`.
    - If the byte equals ACK: pop, increment `ack_cnt`, reset the retry count, go to IDLE.
    - Otherwise: treat as a failure.
  - When the counter reaches TO_CYCLES-1 without `resp_rx_rdy`: treat as a failure. `last_resp` is unchanged and there is no clear pulse.
  - `resp_rx_rdy` on the same cycle as the timeout wins; the response is processed.
- Failure handling:
  - If the retry count is below MAX_RETRY: increment it and go to IDLE. The same head is resent and is not popped.
  - Otherwise: pop, set `err`, reset the retry count, go to IDLE.
- `resp_rx_rdy` seen in IDLE, SEND or WAIT_SNT is a stale byte. It is cleared with `resp_clr_rx_rdy` and ignored; `last_resp` is not updated.
- `err_clr` clears `err` and `ovf`. If `err_clr` coincides with a new error or overflow event, the set wins.

## Timing
- Reset values:
  - 0: `snd_cmd`, `resp_clr_rx_rdy`, `cmd`, `busy`, `last_resp`, `ack_cnt`, `err`, `ovf`, `full`.
  - 1: `empty`.
  - FIFO pointers, retry count and timeout counter are 0; FSM is in IDLE.
- Reset mid-operation:
  - All state clears immediately and queued commands are lost.
  - `snd_cmd` drops asynchronously; no partial pulse persists.
- All outputs are registered.
- Push-to-send latency:
  - Push sampled at edge N makes `empty`=0 after edge N.
  - From IDLE, `snd_cmd`=1 during cycle N+2 (after edge N+2) for exactly one cycle; `cmd` is valid from the same edge.
- `resp_clr_rx_rdy` is high for the one cycle after the edge that samples `resp_rx_rdy`=1.
- ACK-to-next-send:
  - The pop and the transition to IDLE happen on the same edge as the clear pulse.
  - The next `snd_cmd` follows 2 edges later if the FIFO is non-empty.
- `busy` is high from the SEND entry edge to the edge that returns to IDLE.

## Test plan
- Single command, ACK:
  - Stimulus: push 16'h1234; respond with `cmd_snt`, then `resp_rx_rdy` with 8'hA5.
  - Required: one `snd_cmd` with `cmd`=16'h1234, `ack_cnt`=1, `empty`=1, `err`=0, `last_resp`=8'hA5.
- Fill and overflow:
  - Stimulus: with FSM stalled in WAIT_SNT, push 5 commands (DEPTH=4).
  - Required: `full`=1 after the 4th push, `ovf`=1 after the 5th. After all are ACKed, `ack_cnt`=4 and the commands are sent in push order.
- NAK retry then ACK:
  - Stimulus: respond 8'h5A, then 8'hA5.
  - Required: same `cmd` sent twice, `ack_cnt`=1, `err`=0.
- Retries exhausted:
  - Stimulus: respond 8'h00 three times (MAX_RETRY=2).
  - Required: 3 `snd_cmd` pulses, then the entry is popped and `err`=1. `err_clr` returns `err` to 0.
- Timeout:
  - Stimulus: TO_CYCLES=100; give no response after `cmd_snt`.
  - Required: resend occurs 100 cycles later. `resp_rx_rdy` on the timeout cycle is processed as a response, not as a timeout.
- Reset and stale byte:
  - Stimulus: assert `rst_n`=0 in WAIT_RESP; after reset, raise `resp_rx_rdy` in IDLE.
  - Required: all outputs hold their reset values. The stale byte gets a clear pulse, and `last_resp` stays 0.
